icache_port_arbiter: RTL and testbench

//  Shares the single-port ICache block RAM between two requesters: the instruction fetch

---
 rtl/icache_port_arbiter_if.sv | 34 +++
 rtl/icache_port_arbiter.sv | 76 +++++++
 tb/tb_icache_port_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/icache_port_arbiter_if.sv
// rtl/icache_port_arbiter_if.sv - fetch/loader request and ICache RAM signal bundle
interface icache_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;
    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;

    // Arbiter side
    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, douta,
        output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, wea, addra, dina
    );

    // Requesters plus RAM side
    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, douta,
        input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, wea, addra, dina
    );
endinterface

// File: rtl/icache_port_arbiter.sv
// rtl/icache_port_arbiter.sv - loader-priority arbiter for the single-port ICache RAM
module icache_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clka,
    input  logic                  rsta_n,
    icache_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FETCH_RD, LOAD_RD, LOAD_WR} owner_t;

    owner_t            state;
    owner_t            state_nxt;
    logic [3:0]        starve_cnt;
    logic [3:0]        starve_nxt;
    logic              starve_at_max;
    logic              f_gnt_c;
    logic              l_gnt_c;
    logic              wea_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] din_c;

    assign starve_at_max = (starve_cnt == 4'(STARVE_MAX));

    // Grant decision, RAM drive and next owner/starvation state for this cycle
    always_comb begin
        f_gnt_c    = 1'b0;
        l_gnt_c    = 1'b0;
        wea_c      = 1'b0;
        addr_c     = '0;
        din_c      = '0;
        state_nxt  = IDLE;
        starve_nxt = starve_cnt;
        if (rsta_n) begin
            // Loader wins unless fetch has waited through STARVE_MAX loader grants
            f_gnt_c = bus.f_req && (!bus.l_req || starve_at_max);
            l_gnt_c = bus.l_req && !f_gnt_c;
            if (f_gnt_c) begin
                addr_c    = bus.f_addr;
                state_nxt = FETCH_RD;
            end else if (l_gnt_c) begin
                addr_c    = bus.l_addr;
                din_c     = bus.l_wdata;
                wea_c     = bus.l_we;
                state_nxt = bus.l_we ? LOAD_WR : LOAD_RD;
            end
            if (!bus.f_req || f_gnt_c) begin
                starve_nxt = 4'd0;
            end else if (l_gnt_c && !starve_at_max) begin
                starve_nxt = starve_cnt + 4'd1;
            end
        end
    end

    // Owner of the RAM access issued last cycle, plus fetch starvation count
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    assign bus.f_gnt    = f_gnt_c;
    assign bus.l_gnt    = l_gnt_c;
    assign bus.wea      = wea_c;
    assign bus.addra    = addr_c;
    assign bus.dina     = din_c;
    assign bus.f_rvalid = (state == FETCH_RD);
    assign bus.l_rvalid = (state == LOAD_RD);
    assign bus.f_rdata  = bus.douta;
    assign bus.l_rdata  = bus.douta;
endmodule

// File: tb/tb_icache_port_arbiter.sv
// tb/tb_icache_port_arbiter.sv - scoreboard bench for icache_port_arbiter
module tb_icache_port_arbiter;
    localparam int SMAX = 4;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [31:0] ram [256];
    logic [31:0] model_mem [256];
    exp_t        f_q[$];
    exp_t        l_q[$];
    exp_t        item;

    int          sc = 0;
    logic        efg, elg, ewea;
    logic [15:0] eaddr;
    logic [31:0] edin;

    icache_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    icache_port_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .clka   (clk),
        .rsta_n (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM stand-in with 1-cycle read latency
    always @(posedge clk) begin
        if (bus.wea) ram[bus.addra[7:0]] <= bus.dina;
        bus.douta <= ram[bus.addra[7:0]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: grant rules, RAM drive and expected read data
    always @(negedge clk) begin
        efg = 1'b0; elg = 1'b0; ewea = 1'b0; eaddr = 16'h0; edin = 32'h0;
        if (!rst_n) begin
            sc = 0;
        end else begin
            efg = bus.f_req && (!bus.l_req || sc == SMAX);
            elg = bus.l_req && !efg;
        end
        check("gnt", {62'h0, bus.f_gnt, bus.l_gnt}, {62'h0, efg, elg});
        if (efg) eaddr = bus.f_addr;
        if (elg) begin
            eaddr = bus.l_addr;
            ewea  = bus.l_we;
            edin  = bus.l_wdata;
            check("ram_dina", {32'h0, bus.dina}, {32'h0, edin});
        end
        if (!efg && !elg) check("ram_dina_idle", {32'h0, bus.dina}, 64'h0);
        check("ram_wea", {63'h0, bus.wea}, {63'h0, ewea});
        check("ram_addra", {48'h0, bus.addra}, {48'h0, eaddr});
        if (efg) f_q.push_back('{cyc + 1, model_mem[bus.f_addr[7:0]]});
        if (elg && !bus.l_we) l_q.push_back('{cyc + 1, model_mem[bus.l_addr[7:0]]});
        if (elg && bus.l_we) model_mem[bus.l_addr[7:0]] = bus.l_wdata;
        if (rst_n) begin
            if (!bus.f_req || efg) sc = 0;
            else if (elg && sc < SMAX) sc = sc + 1;
        end
    end

    // Monitor: pop expected read data when the DUT presents rvalid
    always @(negedge clk) begin
        if (!rst_n) begin
            f_q.delete();
            l_q.delete();
            check("rvalid_in_reset", {62'h0, bus.f_rvalid, bus.l_rvalid}, 64'h0);
        end else begin
            if (f_q.size() > 0 && f_q[0].due == cyc) begin
                item = f_q.pop_front();
                check("f_rvalid", {63'h0, bus.f_rvalid}, 64'h1);
                if (bus.f_rvalid) check("f_rdata", {32'h0, bus.f_rdata}, {32'h0, item.data});
            end else if (bus.f_rvalid) begin
                check("f_rvalid_unexpected", 64'h1, 64'h0);
            end
            if (l_q.size() > 0 && l_q[0].due == cyc) begin
                item = l_q.pop_front();
                check("l_rvalid", {63'h0, bus.l_rvalid}, 64'h1);
                if (bus.l_rvalid) check("l_rdata", {32'h0, bus.l_rdata}, {32'h0, item.data});
            end else if (bus.l_rvalid) begin
                check("l_rvalid_unexpected", 64'h1, 64'h0);
            end
        end
    end

    task automatic drive(input logic fr, input logic [15:0] fa, input logic lr,
                         input logic lw, input logic [15:0] la, input logic [31:0] ld);
        @(posedge clk);
        #1;
        bus.f_req = fr; bus.f_addr = fa;
        bus.l_req = lr; bus.l_we = lw; bus.l_addr = la; bus.l_wdata = ld;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pfg, plg;
        for (int i = 0; i < 256; i++) begin
            ram[i] = $urandom;
            model_mem[i] = ram[i];
        end
        bus.f_req = 1'b1; bus.f_addr = 16'h0003;
        bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 16'h0007; bus.l_wdata = 32'h1234_5678;

        // Reset with both requests asserted
        @(negedge clk);
        check("reset_outputs", {58'h0, bus.f_gnt, bus.l_gnt, bus.f_rvalid, bus.l_rvalid, bus.wea, 1'b0},
              64'h0);
        check("reset_addra", {48'h0, bus.addra}, 64'h0);
        @(negedge clk);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
        rst_n = 1'b1;

        // Fetch only, four consecutive words
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'(i), 1'b0, 1'b0, 16'h0, 32'h0);
            @(negedge clk);
            check("fetch_gnt", {63'h0, bus.f_gnt}, 64'h1);
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);

        // Loader write then fetch of the same address
        drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF);
        @(negedge clk);
        check("write_wea", {63'h0, bus.wea}, 64'h1);
        drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        check("wr_then_rd", {31'h0, bus.f_rvalid, bus.f_rdata}, {31'h0, 1'b1, 32'hDEAD_BEEF});

        // Starvation: both held high, expect L,L,L,L,F repeating
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'h0040, 1'b1, 1'b0, 16'(8'h80 + i), 32'h0);
            @(negedge clk);
            check("starve_pattern", {62'h0, bus.f_gnt, bus.l_gnt},
                  (i % 5 == 4) ? 64'h2 : 64'h1);
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);

        // Loader read contends with fetch, fetch follows once loader drops
        drive(1'b1, 16'h0030, 1'b1, 1'b0, 16'h0020, 32'h0);
        @(negedge clk);
        check("contend_lgnt", {62'h0, bus.f_gnt, bus.l_gnt}, 64'h1);
        drive(1'b1, 16'h0030, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        check("contend_follow", {60'h0, bus.f_gnt, bus.l_gnt, bus.f_rvalid, bus.l_rvalid}, 64'h9);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);

        // Reset asserted one clock after a fetch grant
        drive(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        check("pre_reset_fgnt", {63'h0, bus.f_gnt}, 64'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.l_req = 1'b1;
        @(negedge clk);
        check("reset_kills_rvalid", {62'h0, bus.f_rvalid, bus.l_rvalid}, 64'h0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {62'h0, bus.f_rvalid, bus.l_rvalid}, 64'h0);

        // Randomized traffic, requests may be held or withdrawn
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            pfg = bus.f_gnt;
            plg = bus.l_gnt;
            @(posedge clk);
            #1;
            if (!bus.f_req || pfg || $urandom_range(0, 7) == 0) begin
                bus.f_req  = ($urandom_range(0, 3) != 0);
                bus.f_addr = {8'h00, 8'($urandom)};
            end
            if (!bus.l_req || plg || $urandom_range(0, 7) == 0) begin
                bus.l_req   = ($urandom_range(0, 2) == 0);
                bus.l_we    = 1'($urandom);
                bus.l_addr  = {8'h00, 8'($urandom)};
                bus.l_wdata = $urandom;
            end
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("queues_drained", {32'h0, 32'(f_q.size() + l_q.size())}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
